// File: rtl/ctrl_unit_gen.sv
// Multi-cycle CPU control sequencer: one-hot phase vector, decoded instruction classes,
// memory handshake with timeout, fetch halt and interrupt entry via a PC-save pseudo-instruction.
module ctrl_unit_gen #(
    parameter int INSTR_W      = 16,
    parameter int MEM_TIMEOUT  = 255,
    parameter int IRQ_NUM_WAIT = 2
) (
    input  logic               I_clk,
    input  logic               I_reset,
    input  logic [INSTR_W-1:0] I_instruction,
    input  logic               I_mem_op,
    input  logic               I_mem_read,
    input  logic               I_dual_write,
    input  logic               I_mem_ready,
    input  logic               I_data_ready,
    input  logic               I_irq_enabled,
    input  logic               I_irq_active,
    input  logic               I_halt,
    output logic [10:0]        O_state,
    output logic [INSTR_W-1:0] O_instr,
    output logic               O_execute,
    output logic               O_irq_ack,
    output logic               O_push_pc,
    output logic               O_bus_error
);

    localparam logic [10:0] S_FETCH         = 11'b000_0000_0001;
    localparam logic [10:0] S_DECODE        = 11'b000_0000_0010;
    localparam logic [10:0] S_REG_READ      = 11'b000_0000_0100;
    localparam logic [10:0] S_EXEC          = 11'b000_0000_1000;
    localparam logic [10:0] S_STORE         = 11'b000_0001_0000;
    localparam logic [10:0] S_REG_WRITE     = 11'b000_0010_0000;
    localparam logic [10:0] S_EXTRA_WRITE   = 11'b000_0100_0000;
    localparam logic [10:0] S_FETCH_IRQ_NUM = 11'b000_1000_0000;
    localparam logic [10:0] S_SAVE_PC       = 11'b001_0000_0000;
    localparam logic [10:0] S_ENTER_ISR     = 11'b010_0000_0000;
    localparam logic [10:0] S_BUS_ERROR     = 11'b100_0000_0000;

    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam int IRQ_W = (IRQ_NUM_WAIT > 1) ? $clog2(IRQ_NUM_WAIT) : 1;
    localparam logic [IRQ_W-1:0] IRQ_LAST = IRQ_W'((IRQ_NUM_WAIT > 0) ? IRQ_NUM_WAIT - 1 : 0);

    logic [10:0]        state;
    logic [INSTR_W-1:0] instr;
    logic               execute;
    logic               irq_ack;
    logic               push_pc;
    logic               bus_error;
    logic               mem_wait;
    logic               irq_save_pc;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [IRQ_W-1:0]   irq_cnt;

    logic mem_done;
    logic tmo_hit;
    logic irq_take;
    logic issue_ok;

    // A write-type STORE completes on I_mem_ready; fetches and loads complete on read data.
    assign mem_done = mem_wait && ((state == S_STORE && !I_mem_read) ? I_mem_ready : I_data_ready);
    assign tmo_hit  = (MEM_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign irq_take = I_irq_enabled && I_irq_active && !irq_save_pc;
    assign issue_ok = I_mem_ready && !(state == S_FETCH && I_halt);

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state       <= S_FETCH;
            instr       <= '0;
            execute     <= 1'b0;
            irq_ack     <= 1'b0;
            push_pc     <= 1'b0;
            bus_error   <= 1'b0;
            mem_wait    <= 1'b0;
            irq_save_pc <= 1'b0;
            tmo_cnt     <= '0;
            irq_cnt     <= '0;
        end else begin
            // NOTE: strobes default low each cycle so a single assignment below yields a one-cycle pulse.
            execute   <= 1'b0;
            irq_ack   <= 1'b0;
            bus_error <= 1'b0;

            case (state)
                S_FETCH, S_STORE: begin
                    if (!mem_wait) begin
                        if (issue_ok) begin
                            execute  <= 1'b1;
                            mem_wait <= 1'b1;
                            tmo_cnt  <= '0;
                        end
                    end else if (mem_done) begin
                        mem_wait <= 1'b0;
                        state    <= (state == S_FETCH) ? S_DECODE : S_REG_WRITE;
                    end else if (tmo_hit) begin
                        mem_wait  <= 1'b0;
                        bus_error <= 1'b1;
                        state     <= S_BUS_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_DECODE: begin
                    instr <= I_instruction;
                    state <= S_REG_READ;
                end
                S_REG_READ: state <= S_EXEC;
                S_EXEC:     state <= I_mem_op ? S_STORE : S_REG_WRITE;
                S_REG_WRITE, S_EXTRA_WRITE: begin
                    if (state == S_REG_WRITE && I_dual_write) begin
                        state <= S_EXTRA_WRITE;
                    end else if (irq_take) begin
                        irq_ack <= 1'b1;
                        irq_cnt <= '0;
                        state   <= S_FETCH_IRQ_NUM;
                    end else if (irq_save_pc) begin
                        irq_save_pc <= 1'b0;
                        push_pc     <= 1'b0;
                        state       <= S_ENTER_ISR;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH_IRQ_NUM: begin
                    if (irq_cnt == IRQ_LAST) begin
                        state <= S_SAVE_PC;
                    end else begin
                        irq_cnt <= irq_cnt + IRQ_W'(1);
                    end
                end
                // The PC push replays DECODE..REG_WRITE as a pseudo-instruction.
                S_SAVE_PC: begin
                    irq_save_pc <= 1'b1;
                    push_pc     <= 1'b1;
                    state       <= S_DECODE;
                end
                S_ENTER_ISR, S_BUS_ERROR: state <= S_FETCH;
                default: begin
                    mem_wait <= 1'b0;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

    assign O_state     = state;
    assign O_instr     = instr;
    assign O_execute   = execute;
    assign O_irq_ack   = irq_ack;
    assign O_push_pc   = push_pc;
    assign O_bus_error = bus_error;

endmodule
